// File: rtl/fir_ctrl_pkg.sv
// Shared definitions for the FIR core controller: controller states,
// default parameter values and a small saturating-increment helper.
package fir_ctrl_pkg;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_N_TAPS  = 128;
    localparam int DEF_TMO_CYC = 1024;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_DONE,
        OUT,
        FL_START,
        FL_WAIT
    } state_t;

    // Increment a 16-bit counter, holding at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/fir_ctrl_wdog.sv
// Watchdog for the controller's wait states. The count is cleared when a
// wait state is entered and advances while enabled; tmo pulses high during
// the TMO_CYC-th enabled cycle after the clear.
module fir_ctrl_wdog
    import fir_ctrl_pkg::*;
#(
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic ap_clk,
    input  logic ap_rst_n,
    input  logic clr,
    input  logic en,
    output logic tmo
);

    localparam int CW = $clog2(TMO_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TMO_CYC - 1);

    logic [CW-1:0] cnt;

    // Cycle counter: cleared on wait-state entry, parks at the limit value.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != LAST)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tmo = en && (cnt == LAST);

endmodule

// File: rtl/fir_ctrl.sv
// Streaming front end for a handshake-driven FIR core. Accepts one sample
// at a time, runs it through the core, and presents the result with a
// valid/ready handshake. A flush request pushes N_TAPS zero samples
// through the core to clear its tap history, discarding the results.
// A watchdog aborts any wait for the core that exceeds TMO_CYC cycles.
// Optional feature macro FIR_CTRL_PERF_EN adds lat_last/lat_max latency
// monitors for regular (non-flush) transactions.
module fir_ctrl
    import fir_ctrl_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int N_TAPS  = DEF_N_TAPS,
    parameter int TMO_CYC = DEF_TMO_CYC
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              core_ap_start,
    input  logic              core_ap_ready,
    input  logic              core_ap_done,
    output logic [DATA_W-1:0] core_x,
    input  logic [DATA_W-1:0] core_y,
    input  logic              cfg_flush,
    output logic              busy,
    output logic              err_tmo,
    output logic [31:0]       sample_cnt
`ifdef FIR_CTRL_PERF_EN
    ,
    output logic [15:0]       lat_last,
    output logic [15:0]       lat_max
`endif
);

    localparam int FCW = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam logic [FCW-1:0] FL_LAST = FCW'(N_TAPS - 1);

    state_t         state;
    state_t         state_nxt;
    logic           rdy_en;
    logic           flush_pend;
    logic [FCW-1:0] flush_cnt;
    logic           in_flush;

    logic           s_accept;
    logic           capture;
    logic           deliver;
    logic           fl_begin;
    logic           fl_step;
    logic           fl_end;
    logic           tmo_hit;
    logic           wd_clr;
    logic           wd_en;
    logic           wd_tmo;

    assign in_flush = (state == FL_START) || (state == FL_WAIT);

    fir_ctrl_wdog #(
        .TMO_CYC (TMO_CYC)
    ) u_wdog (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .clr      (wd_clr),
        .en       (wd_en),
        .tmo      (wd_tmo)
    );

    // State register.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic, handshake outputs and datapath strobes.
    always_comb begin
        state_nxt     = state;
        s_ready       = 1'b0;
        m_valid       = 1'b0;
        core_ap_start = 1'b0;
        s_accept      = 1'b0;
        capture       = 1'b0;
        deliver       = 1'b0;
        fl_begin      = 1'b0;
        fl_step       = 1'b0;
        fl_end        = 1'b0;
        tmo_hit       = 1'b0;
        wd_clr        = 1'b0;
        wd_en         = 1'b0;
        busy          = (state != IDLE);
        case (state)
            IDLE: begin
                if (rdy_en) begin
                    if (flush_pend || cfg_flush) begin
                        fl_begin  = 1'b1;
                        state_nxt = FL_START;
                    end else begin
                        s_ready = 1'b1;
                        if (s_valid) begin
                            s_accept  = 1'b1;
                            state_nxt = START;
                        end
                    end
                end
            end
            START: begin
                core_ap_start = 1'b1;
                if (core_ap_ready) begin
                    wd_clr    = 1'b1;
                    state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                wd_en = 1'b1;
                if (core_ap_done) begin
                    capture   = 1'b1;
                    state_nxt = OUT;
                end else if (wd_tmo) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                m_valid = 1'b1;
                if (m_ready) begin
                    deliver   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            FL_START: begin
                core_ap_start = 1'b1;
                if (core_ap_ready) begin
                    wd_clr    = 1'b1;
                    state_nxt = FL_WAIT;
                end
            end
            FL_WAIT: begin
                wd_en = 1'b1;
                if (core_ap_done) begin
                    if (flush_cnt == FL_LAST) begin
                        fl_end    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        fl_step   = 1'b1;
                        state_nxt = FL_START;
                    end
                end else if (wd_tmo) begin
                    tmo_hit   = 1'b1;
                    fl_end    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath registers: sample/result capture, counters and flags.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            rdy_en     <= 1'b0;
            core_x     <= '0;
            m_data     <= '0;
            sample_cnt <= '0;
            err_tmo    <= 1'b0;
            flush_pend <= 1'b0;
            flush_cnt  <= '0;
        end else begin
            rdy_en <= 1'b1;
            if (s_accept) begin
                core_x <= s_data;
            end else if (fl_begin) begin
                core_x <= '0;
            end
            if (capture) begin
                m_data <= core_y;
            end
            if (deliver) begin
                sample_cnt <= sample_cnt + 32'd1;
            end
            if (tmo_hit) begin
                err_tmo <= 1'b1;
            end
            if (fl_end) begin
                flush_pend <= 1'b0;
            end else if (cfg_flush && !in_flush) begin
                flush_pend <= 1'b1;
            end
            if (fl_begin) begin
                flush_cnt <= '0;
            end else if (fl_step) begin
                flush_cnt <= flush_cnt + FCW'(1);
            end
        end
    end

`ifdef FIR_CTRL_PERF_EN
    logic [15:0] lat_cnt;

    // Latency monitor: counts from the first start cycle to the done cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            lat_cnt  <= '0;
            lat_last <= '0;
            lat_max  <= '0;
        end else begin
            if (s_accept) begin
                lat_cnt <= 16'd1;
            end else if ((state == START) || (state == WAIT_DONE)) begin
                lat_cnt <= sat_inc16(lat_cnt);
            end
            if (capture) begin
                lat_last <= lat_cnt;
                if (lat_cnt > lat_max) begin
                    lat_max <= lat_cnt;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_fir_ctrl.sv
// Self-checking bench for fir_ctrl. A behavioural FIR core answers each
// start with x*2 after a programmable latency; expected results, counts
// and flush behaviour come from plain arithmetic on the accepted samples.
module tb_fir_ctrl;

    localparam int DW  = 32;
    localparam int NT  = 128;
    localparam int TMO = 1024;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          core_ap_start;
    logic          core_ap_ready = 1'b0;
    logic          core_ap_done = 1'b0;
    logic [DW-1:0] core_x;
    logic [DW-1:0] core_y = '0;
    logic          cfg_flush = 1'b0;
    logic          busy;
    logic          err_tmo;
    logic [31:0]   sample_cnt;
`ifdef FIR_CTRL_PERF_EN
    logic [15:0]   lat_last;
    logic [15:0]   lat_max;
`endif

    int total = 0;
    int bad = 0;
    int exp_cnt = 0;
    int pcyc = 0;

    // core model state and knobs
    int            lat_cfg = 3;
    int            rdy_max = 2;
    bit            never_done = 1'b0;
    bit            inject_done = 1'b0;
    bit            model_clear = 1'b0;
    int            hs_count = 0;
    int            overlap_cnt = 0;
    logic [DW-1:0] xq[$];
    int            rdy_wait = 0;
    bit            in_flight = 1'b0;
    int            cd = 0;
    logic [DW-1:0] x_cap = '0;
    int            done_pcyc = 0;
    int            rdy_pcyc = 0;
    int            start_first_pcyc = 0;
    bit            prev_start = 1'b0;

    fir_ctrl #(
        .DATA_W  (DW),
        .N_TAPS  (NT),
        .TMO_CYC (TMO)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst_n      (ap_rst_n),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .s_data        (s_data),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_data        (m_data),
        .core_ap_start (core_ap_start),
        .core_ap_ready (core_ap_ready),
        .core_ap_done  (core_ap_done),
        .core_x        (core_x),
        .core_y        (core_y),
        .cfg_flush     (cfg_flush),
        .busy          (busy),
        .err_tmo       (err_tmo),
        .sample_cnt    (sample_cnt)
`ifdef FIR_CTRL_PERF_EN
        ,
        .lat_last      (lat_last),
        .lat_max       (lat_max)
`endif
    );

    always #5 ap_clk = ~ap_clk;

    // free-running cycle index, advanced on every rising edge
    always @(posedge ap_clk) pcyc <= pcyc + 1;

    // behavioural FIR core: ready after a random wait, done pulse lat_cfg cycles later
    always @(negedge ap_clk) begin
        if (!ap_rst_n || model_clear) begin
            core_ap_ready = 1'b0;
            core_ap_done  = 1'b0;
            in_flight     = 1'b0;
            cd            = 0;
            rdy_wait      = 0;
            prev_start    = 1'b0;
        end else begin
            core_ap_ready = 1'b0;
            core_ap_done  = 1'b0;
            if (core_ap_start && !prev_start) start_first_pcyc = pcyc;
            prev_start = core_ap_start;
            if (in_flight && core_ap_start) overlap_cnt++;
            if (inject_done) begin
                core_ap_done = 1'b1;
                core_y = 32'hDEAD_BEEF;
            end else if (in_flight) begin
                if (cd > 0) cd--;
                if (cd == 0 && !never_done) begin
                    core_ap_done = 1'b1;
                    core_y = x_cap * 2;
                    in_flight = 1'b0;
                    done_pcyc = pcyc;
                end
            end else if (core_ap_start) begin
                if (rdy_wait == 0) begin
                    core_ap_ready = 1'b1;
                    x_cap = core_x;
                    in_flight = 1'b1;
                    cd = lat_cfg;
                    hs_count++;
                    xq.push_back(core_x);
                    rdy_pcyc = pcyc;
                    rdy_wait = $urandom_range(rdy_max, 0);
                end else begin
                    rdy_wait--;
                end
            end
        end
    end

    task automatic clear_model();
        @(negedge ap_clk);
        #1 model_clear = 1'b1;
        @(negedge ap_clk);
        #1 model_clear = 1'b0;
    endtask

    // one full sample transaction; returns what was observed
    task automatic do_txn(input logic [DW-1:0] d, input int mdelay,
                          output logic [DW-1:0] got, output bit ok,
                          output bit stable, output bit start_ok, output int mv_pcyc);
        int t;
        ok = 1'b0; stable = 1'b1; start_ok = 1'b0; got = '0; mv_pcyc = 0;
        @(negedge ap_clk);
        s_data = d;
        s_valid = 1'b1;
        #1;
        t = 0;
        while (!s_ready && t < 4000) begin
            @(negedge ap_clk); #1; t++;
        end
        if (!s_ready) begin
            s_valid = 1'b0;
            return;
        end
        @(posedge ap_clk);
        #1 s_valid = 1'b0;
        start_ok = core_ap_start && (core_x === d);
        t = 0;
        @(negedge ap_clk);
        while (!m_valid && t < 4000) begin
            @(negedge ap_clk); t++;
        end
        if (!m_valid) return;
        mv_pcyc = pcyc;
        got = m_data;
        repeat (mdelay) begin
            @(negedge ap_clk);
            if (!m_valid || m_data !== got || s_ready) stable = 1'b0;
        end
        m_ready = 1'b1;
        @(posedge ap_clk);
        #1 m_ready = 1'b0;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        ap_rst_n = 1'b0;
        repeat (3) @(negedge ap_clk);
        #1;
        total++;
        if (s_ready !== 1'b0 || m_valid !== 1'b0 || core_ap_start !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_ctrl: got rdy=%b mv=%b st=%b busy=%b want 0000", s_ready, m_valid, core_ap_start, busy);
        end
        total++;
        if (m_data !== '0 || core_x !== '0 || sample_cnt !== 32'd0 || err_tmo !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_data: got m_data=%h core_x=%h cnt=%0d err=%b want zeros", m_data, core_x, sample_cnt, err_tmo);
        end
`ifdef FIR_CTRL_PERF_EN
        total++;
        if (lat_last !== 16'd0 || lat_max !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_lat: got %0d/%0d want 0/0", lat_last, lat_max);
        end
`endif
        ap_rst_n = 1'b1;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL ready_at_release: got %b want 0", s_ready);
        end
        @(negedge ap_clk);
        #1;
        total++;
        if (s_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL ready_after_release: got %b want 1", s_ready);
        end
        exp_cnt = 0;
    endtask

    task automatic test_sample5();
        logic [DW-1:0] got; bit ok, st, sok; int mv;
        clear_model();
        rdy_max = 0;
        lat_cfg = 3 * 128;
        do_txn(32'd5, 0, got, ok, st, sok, mv);
        if (ok) exp_cnt++;
        total++;
        if (!ok || got !== 32'd10) begin
            bad++;
            $display("[TB] FAIL sample5_data: got %0d ok=%b want 10", got, ok);
        end
        total++;
        if (sample_cnt !== 32'(exp_cnt) || exp_cnt != 1) begin
            bad++;
            $display("[TB] FAIL sample5_cnt: got %0d want 1", sample_cnt);
        end
        total++;
        if (!sok) begin
            bad++;
            $display("[TB] FAIL start_latency: got start=%b x=%h want 1 and 5 the cycle after accept", core_ap_start, core_x);
        end
        total++;
        if (mv != done_pcyc + 1) begin
            bad++;
            $display("[TB] FAIL done_to_valid: got cycle %0d want %0d", mv, done_pcyc + 1);
        end
        total++;
        if (m_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL after_deliver: got mv=%b busy=%b want 0 0", m_valid, busy);
        end
`ifdef FIR_CTRL_PERF_EN
        total++;
        if (lat_last !== 16'd385 || lat_max !== 16'd385 || (done_pcyc + 1 - start_first_pcyc) != 385) begin
            bad++;
            $display("[TB] FAIL sample5_lat: got last=%0d max=%0d want 385", lat_last, lat_max);
        end
`endif
    endtask

    task automatic test_backpressure();
        logic [DW-1:0] got, d; bit ok, st, sok; int mv;
        clear_model();
        rdy_max = 2;
        lat_cfg = 3;
        d = $urandom;
        do_txn(d, 20, got, ok, st, sok, mv);
        if (ok) exp_cnt++;
        total++;
        if (!ok || !st) begin
            bad++;
            $display("[TB] FAIL backpressure_hold: got ok=%b stable=%b want 1 1", ok, st);
        end
        total++;
        if (got !== d * 2) begin
            bad++;
            $display("[TB] FAIL backpressure_data: got %h want %h", got, d * 2);
        end
        total++;
        if (sample_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL backpressure_cnt: got %0d want %0d", sample_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush_idle();
        int h0, t, nz; bit mv_seen;
        clear_model();
        rdy_max = 2;
        lat_cfg = 2;
        h0 = hs_count;
        xq.delete();
        mv_seen = 1'b0;
        @(negedge ap_clk);
        #1 cfg_flush = 1'b1;
        @(negedge ap_clk);
        #1 cfg_flush = 1'b0;
        repeat (10) @(negedge ap_clk);
        #1 cfg_flush = 1'b1;
        @(negedge ap_clk);
        #1 cfg_flush = 1'b0;
        t = 0;
        while (busy && t < 20000) begin
            @(negedge ap_clk);
            if (m_valid) mv_seen = 1'b1;
            t++;
        end
        repeat (5) begin
            @(negedge ap_clk);
            if (m_valid || busy) mv_seen = 1'b1;
        end
        nz = 0;
        foreach (xq[i]) if (xq[i] !== '0) nz++;
        total++;
        if (hs_count - h0 != NT) begin
            bad++;
            $display("[TB] FAIL flush_count: got %0d handshakes want %0d", hs_count - h0, NT);
        end
        total++;
        if (nz != 0) begin
            bad++;
            $display("[TB] FAIL flush_zero_x: got %0d nonzero samples want 0", nz);
        end
        total++;
        if (mv_seen) begin
            bad++;
            $display("[TB] FAIL flush_quiet: got m_valid/busy activity want none");
        end
        total++;
        if (sample_cnt !== 32'(exp_cnt) || s_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL flush_cnt: got cnt=%0d rdy=%b want %0d 1", sample_cnt, s_ready, exp_cnt);
        end
    endtask

    task automatic test_flush_and_valid();
        logic [DW-1:0] d; int h0, t;
        clear_model();
        rdy_max = 1;
        lat_cfg = 1;
        d = $urandom;
        h0 = hs_count;
        @(negedge ap_clk);
        cfg_flush = 1'b1;
        s_valid = 1'b1;
        s_data = d;
        #1;
        total++;
        if (s_ready !== 1'b0) begin
            bad++;
            $display("[TB] FAIL flush_wins: got s_ready=%b want 0", s_ready);
        end
        @(posedge ap_clk);
        #1 cfg_flush = 1'b0;
        t = 0;
        @(negedge ap_clk); #1;
        while (!s_ready && t < 20000) begin
            @(negedge ap_clk); #1; t++;
        end
        total++;
        if (!s_ready || hs_count - h0 != NT) begin
            bad++;
            $display("[TB] FAIL flush_first: got %0d handshakes before accept want %0d", hs_count - h0, NT);
        end
        @(posedge ap_clk);
        #1 s_valid = 1'b0;
        t = 0;
        while (!m_valid && t < 200) begin
            @(negedge ap_clk); t++;
        end
        total++;
        if (m_valid !== 1'b1 || m_data !== d * 2) begin
            bad++;
            $display("[TB] FAIL flush_then_sample: got mv=%b data=%h want 1 %h", m_valid, m_data, d * 2);
        end
        m_ready = 1'b1;
        @(posedge ap_clk);
        #1 m_ready = 1'b0;
        if (m_valid === 1'b0) exp_cnt++;
        total++;
        if (sample_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL flush_then_cnt: got %0d want %0d", sample_cnt, exp_cnt);
        end
    endtask

    task automatic test_flush_pending();
        logic [DW-1:0] got, d; bit ok, st, sok; int mv, h0, t;
        clear_model();
        rdy_max = 0;
        lat_cfg = 30;
        d = $urandom;
        h0 = hs_count;
        fork
            do_txn(d, 2, got, ok, st, sok, mv);
            begin
                repeat (8) @(negedge ap_clk);
                #1 cfg_flush = 1'b1;
                @(negedge ap_clk);
                #1 cfg_flush = 1'b0;
            end
        join
        lat_cfg = 2;
        if (ok) exp_cnt++;
        total++;
        if (!ok || got !== d * 2) begin
            bad++;
            $display("[TB] FAIL pending_txn: got %h ok=%b want %h", got, ok, d * 2);
        end
        t = 0;
        while (!busy && t < 20) begin @(negedge ap_clk); t++; end
        while (busy && t < 20000) begin @(negedge ap_clk); t++; end
        total++;
        if (hs_count - h0 != NT + 1 || sample_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL pending_flush: got %0d handshakes cnt=%0d want %0d cnt=%0d", hs_count - h0, sample_cnt, NT + 1, exp_cnt);
        end
    endtask

    task automatic test_spurious_done();
        bit seen;
        seen = 1'b0;
        @(negedge ap_clk);
        #1 inject_done = 1'b1;
        @(negedge ap_clk);
        #1 inject_done = 1'b0;
        repeat (5) begin
            @(negedge ap_clk);
            if (m_valid || busy) seen = 1'b1;
        end
        total++;
        if (seen || sample_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL stray_done: got activity=%b cnt=%0d want 0 %0d", seen, sample_cnt, exp_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [DW-1:0] got, d; bit ok, st, sok; int mv, errs;
        clear_model();
        rdy_max = 3;
        errs = 0;
        overlap_cnt = 0;
        for (int i = 0; i < 25; i++) begin
            d = $urandom;
            lat_cfg = $urandom_range(6, 1);
            do_txn(d, $urandom_range(3, 0), got, ok, st, sok, mv);
            if (ok) exp_cnt++;
            total++;
            if (!ok || !st || got !== d * 2 || sample_cnt !== 32'(exp_cnt)) begin
                bad++;
                $display("[TB] FAIL random_txn%0d: got %h cnt=%0d want %h cnt=%0d", i, got, sample_cnt, d * 2, exp_cnt);
            end
        end
        total++;
        if (overlap_cnt != 0) begin
            bad++;
            $display("[TB] FAIL one_outstanding: got %0d overlapping starts want 0", overlap_cnt);
        end
    endtask

    task automatic test_timeout();
        logic [DW-1:0] got, d; bit ok, st, sok, mv_seen; int mv, t, err_pcyc;
        clear_model();
        rdy_max = 0;
        never_done = 1'b1;
        mv_seen = 1'b0;
        err_pcyc = 0;
        d = $urandom;
        @(negedge ap_clk);
        s_data = d;
        s_valid = 1'b1;
        #1;
        t = 0;
        while (!s_ready && t < 100) begin @(negedge ap_clk); #1; t++; end
        @(posedge ap_clk);
        #1 s_valid = 1'b0;
        t = 0;
        while (!err_tmo && t < 3000) begin
            @(negedge ap_clk);
            if (m_valid) mv_seen = 1'b1;
            t++;
        end
        err_pcyc = pcyc;
        total++;
        if (err_tmo !== 1'b1 || err_pcyc != rdy_pcyc + 1 + TMO) begin
            bad++;
            $display("[TB] FAIL tmo_cycle: got err=%b at %0d want 1 at %0d", err_tmo, err_pcyc, rdy_pcyc + 1 + TMO);
        end
        total++;
        if (busy !== 1'b0 || mv_seen || sample_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("[TB] FAIL tmo_abort: got busy=%b mv=%b cnt=%0d want 0 0 %0d", busy, mv_seen, sample_cnt, exp_cnt);
        end
        never_done = 1'b0;
        clear_model();
        lat_cfg = 4;
        d = $urandom;
        do_txn(d, 1, got, ok, st, sok, mv);
        if (ok) exp_cnt++;
        total++;
        if (!ok || got !== d * 2 || err_tmo !== 1'b1) begin
            bad++;
            $display("[TB] FAIL tmo_sticky: got data=%h err=%b want %h 1", got, err_tmo, d * 2);
        end
    endtask

    task automatic test_reset_mid();
        int t; bit mv_seen;
        clear_model();
        rdy_max = 0;
        lat_cfg = 60;
        @(negedge ap_clk);
        s_data = $urandom;
        s_valid = 1'b1;
        #1;
        t = 0;
        while (!s_ready && t < 100) begin @(negedge ap_clk); #1; t++; end
        @(posedge ap_clk);
        #1 s_valid = 1'b0;
        repeat (10) @(negedge ap_clk);
        #2 ap_rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || m_valid !== 1'b0 || core_ap_start !== 1'b0 || s_ready !== 1'b0 ||
            err_tmo !== 1'b0 || sample_cnt !== 32'd0 || m_data !== '0 || core_x !== '0) begin
            bad++;
            $display("[TB] FAIL reset_mid: got busy=%b mv=%b st=%b rdy=%b err=%b cnt=%0d want all 0", busy, m_valid, core_ap_start, s_ready, err_tmo, sample_cnt);
        end
`ifdef FIR_CTRL_PERF_EN
        total++;
        if (lat_last !== 16'd0 || lat_max !== 16'd0) begin
            bad++;
            $display("[TB] FAIL reset_mid_lat: got %0d/%0d want 0/0", lat_last, lat_max);
        end
`endif
        repeat (3) @(negedge ap_clk);
        ap_rst_n = 1'b1;
        exp_cnt = 0;
        mv_seen = 1'b0;
        repeat (100) begin
            @(negedge ap_clk);
            if (m_valid || busy) mv_seen = 1'b1;
        end
        total++;
        if (mv_seen || s_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL reset_mid_quiet: got activity=%b rdy=%b want 0 1", mv_seen, s_ready);
        end
    endtask

    initial begin
        $display("[TB] fir_ctrl bench start");
        test_reset();
        test_sample5();
        test_backpressure();
        test_flush_idle();
        test_flush_and_valid();
        test_flush_pending();
        test_spurious_done();
        test_back_to_back();
        test_timeout();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fir_ctrl.md
FIR_CTRL -- requirements
Module: fir_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning sample/result width.
REQ-002 SHALL have parameter N_TAPS, default 128, meaning number of zero samples per flush.
REQ-003 SHALL have parameter TMO_CYC, default 1024, meaning the WAIT_DONE watchdog limit in cycles.
REQ-004 SHALL have ports, one clock and asynchronous active-low reset:
- ap_clk  in  1  clock.
- ap_rst_n  in  1  reset, asynchronous, active-low.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input sample accepted when high with s_valid.
- s_data  in  DATA_W  input sample.
- m_valid  out  1  result valid.
- m_ready  in  1  result consumer ready.
- m_data  out  DATA_W  filtered result.
- core_ap_start  out  1  start of FIR core.
- core_ap_ready  in  1  core has consumed core_x.
- core_ap_done  in  1  core result valid, one-cycle pulse.
- core_x  out  DATA_W  sample presented to core.
- core_y  in  DATA_W  core result, valid with core_ap_done.
- cfg_flush  in  1  pulse requesting a tap-history flush.
- busy  out  1  FSM not in IDLE.
- err_tmo  out  1  sticky watchdog error.
- sample_cnt  out  32  count of delivered results, excluding flush results.

Function
REQ-005 SHALL implement states IDLE, START, WAIT_DONE, OUT, FL_START and FL_WAIT.
REQ-006 IDLE: s_ready=1 only in IDLE when no flush is pending, and s_valid&&s_ready latches s_data into core_x and moves to START.
REQ-007 START: core_ap_start=1, held until core_ap_ready=1, then go to WAIT_DONE.
REQ-008 WAIT_DONE: on core_ap_done, capture core_y into m_data and go to OUT.
REQ-009 OUT: m_valid=1, m_data stable until m_ready; on m_ready, sample_cnt+1 and return to IDLE.
REQ-010 sample_cnt SHALL wrap from 0xFFFFFFFF to 0.
REQ-011 cfg_flush SHALL set a pending flag in any state; pending is serviced only from IDLE; a flush pulse during a flush is ignored.
REQ-012 A flush SHALL run N_TAPS transactions with core_x=0 via FL_START/FL_WAIT; results are discarded (m_valid stays 0) and sample_cnt is unchanged.
REQ-013 Flush counter SHALL count 0..N_TAPS-1, then return to IDLE and clear pending.
REQ-014 When cfg_flush and s_valid are both high in IDLE, flush SHALL win and s_ready SHALL be 0.
REQ-015 Watchdog: cycle counter cleared on entry to WAIT_DONE/FL_WAIT; reaching TMO_CYC without core_ap_done sets err_tmo, aborts any flush, goes IDLE.
REQ-016 err_tmo SHALL clear only on reset.
REQ-017 A core_ap_done outside WAIT_DONE/FL_WAIT SHALL be ignored.
REQ-018 Latency: s handshake -> core_ap_start at next cycle; core_ap_done -> m_valid at next cycle.
REQ-019 At most one transaction SHALL be outstanding at the core.

Reset
REQ-020 On ap_rst_n low, asynchronously: state=IDLE; s_ready=0 during reset, 1 one cycle after release; m_valid=0; core_ap_start=0; m_data=0; core_x=0; busy=0; err_tmo=0; sample_cnt=0; flush pending=0; counters=0.
REQ-021 Reset mid-transaction SHALL drop it silently with no output.

Configuration
REQ-022 With macro FIR_CTRL_PERF_EN defined, the block SHALL add outputs lat_last[15:0] and lat_max[15:0], measuring cycles from start assertion to core_ap_done for non-flush transactions.
REQ-023 lat_last and lat_max SHALL saturate at 0xFFFF, with lat_max a running maximum, and both 0 at reset.
REQ-024 Without FIR_CTRL_PERF_EN, those ports and their counters SHALL be absent; all other behaviour is identical.

Structure
REQ-025 Package fir_ctrl_pkg SHALL hold the state enum, default DATA_W, N_TAPS and TMO_CYC constants.
REQ-026 Sub-module fir_ctrl_wdog SHALL hold the watchdog counter, with clear and enable inputs and a tmo pulse output.
REQ-027 The FSM SHALL stay in fir_ctrl.

Verification
REQ-028 Sample 5: with the core model returning x*2 after 3*128 cycles, s_data=5 SHALL yield m_data=10, sample_cnt=1, and lat_last≈385 with PERF.
REQ-029 m_ready held 0 for 20 cycles SHALL keep m_valid=1 with m_data stable and s_ready=0, then a single count.
REQ-030 cfg_flush in IDLE SHALL produce exactly 128 core_ap_start handshakes with core_x=0, m_valid never 1, and sample_cnt unchanged.
REQ-031 cfg_flush and s_valid in the same cycle SHALL run the flush first, then accept the sample.
REQ-032 A core that never asserts done SHALL raise err_tmo at cycle 1024 of WAIT_DONE, return IDLE, and keep err_tmo high until reset.
REQ-033 ap_rst_n low during WAIT_DONE SHALL drive all outputs to reset values immediately, with no m_valid after release.
